// File: rtl/frame_dump_pkg.sv
// Shared types and default widths for the frame-count / dump-window trigger.
package frame_dump_pkg;

    localparam int CW_DEF = 32;
    localparam int LW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } fd_state_e;

endpackage

// File: rtl/frame_dump_if.sv
// Signal bundle between the frame wrapper (master) and the dump trigger (slave).
interface frame_dump_if
    import frame_dump_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int LW = LW_DEF
) ();

    logic          vs;
    logic          downloading;
    logic [CW-1:0] start_frame;
    logic [LW-1:0] dump_len;
    logic [CW-1:0] frame_cnt;
    logic          frame_stb;
    logic          dump_en;
    logic          dump_on;
    logic          dump_off;
    logic [1:0]    state;

    modport master (
        output vs, downloading, start_frame, dump_len,
        input  frame_cnt, frame_stb, dump_en, dump_on, dump_off, state
    );

    modport slave (
        input  vs, downloading, start_frame, dump_len,
        output frame_cnt, frame_stb, dump_en, dump_on, dump_off, state
    );

endinterface

// File: rtl/frame_dump_sync.sv
// Two-flop synchroniser plus history flop; reports the synchronised active level
// and the leading edge of the active pulse for a signal of polarity POL.
module frame_dump_sync #(
    parameter bit POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic act_s,
    output logic lead_s
);

    logic meta_r;
    logic sync_r;
    logic hist_r;

    // Synchroniser chain; resets to the inactive level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= ~POL;
            sync_r <= ~POL;
            hist_r <= ~POL;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
            hist_r <= sync_r;
        end
    end

    // Active level normalised to 1 and leading-edge detect on the synchronised signal.
    always_comb begin
        act_s  = (sync_r == POL);
        lead_s = (sync_r == POL) && (hist_r != POL);
    end

endmodule

// File: rtl/frame_dump_trigger.sv
// Frame counter and dump-window FSM driven by vertical sync.
// Build option DUMP_LOADROM_EN: arm on the end of ROM download, abort when it restarts.
module frame_dump_trigger
    import frame_dump_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int LW     = LW_DEF,
    parameter bit VS_POL = 1'b0
) (
    input logic        clk,
    input logic        rst_n,
    frame_dump_if.slave bus
);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [LW-1:0] LEN_ONE  = LW'(1'b1);
    localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};

    fd_state_e     state_r;
    logic [CW-1:0] frame_cnt_r;
    logic [CW-1:0] cnt_inc_s;
    logic [LW-1:0] len_r;
    logic          frame_stb_r;
    logic          dump_en_r;
    logic          dump_on_r;
    logic          dump_off_r;
    logic          vs_edge_s;
    logic          vs_lvl_unused_s;
    logic          open_s;
    logic          arm_s;
    logic          abort_s;

    frame_dump_sync #(.POL(VS_POL)) u_vs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (bus.vs),
        .act_s  (vs_lvl_unused_s),
        .lead_s (vs_edge_s)
    );

`ifdef DUMP_LOADROM_EN
    logic dl_idle_s;
    logic dl_fall_s;

    // Polarity 0 makes the leading edge the end of the download and "active" mean not loading.
    frame_dump_sync #(.POL(1'b0)) u_dl_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (bus.downloading),
        .act_s  (dl_idle_s),
        .lead_s (dl_fall_s)
    );

    // Arming follows the end of a download; a new download aborts the window.
    always_comb begin
        arm_s   = dl_fall_s;
        abort_s = ~dl_idle_s;
    end
`else
    logic dl_unused_s;

    // Without ROM tracking the trigger arms straight out of reset and never aborts.
    always_comb begin
        arm_s       = 1'b1;
        abort_s     = 1'b0;
        dl_unused_s = bus.downloading;
    end
`endif

    // Next frame number and window-open test; start_frame of 0 means the very first frame.
    always_comb begin
        cnt_inc_s = frame_cnt_r + CNT_ONE;
        open_s    = (cnt_inc_s == bus.start_frame) || (bus.start_frame == CNT_ZERO);
    end

    // Dump-window FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            frame_cnt_r <= CNT_ZERO;
            len_r       <= LEN_ZERO;
            frame_stb_r <= 1'b0;
            dump_en_r   <= 1'b0;
            dump_on_r   <= 1'b0;
            dump_off_r  <= 1'b0;
        end else begin
            frame_stb_r <= vs_edge_s;
            dump_on_r   <= 1'b0;
            dump_off_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (arm_s) begin
                        state_r     <= ARMED;
                        frame_cnt_r <= CNT_ZERO;
                    end
                end
                ARMED: begin
                    if (abort_s) begin
                        state_r     <= IDLE;
                        frame_cnt_r <= CNT_ZERO;
                    end else if (vs_edge_s) begin
                        frame_cnt_r <= cnt_inc_s;
                        if (open_s) begin
                            state_r   <= DUMP;
                            dump_en_r <= 1'b1;
                            dump_on_r <= 1'b1;
                            len_r     <= bus.dump_len;
                        end
                    end
                end
                DUMP: begin
                    if (abort_s) begin
                        state_r     <= IDLE;
                        frame_cnt_r <= CNT_ZERO;
                        dump_en_r   <= 1'b0;
                        dump_off_r  <= 1'b1;
                    end else if (vs_edge_s) begin
                        frame_cnt_r <= cnt_inc_s;
                        // A zero length never counts down, holding the window open until reset.
                        if (len_r == LEN_ONE) begin
                            state_r    <= DONE;
                            len_r      <= LEN_ZERO;
                            dump_en_r  <= 1'b0;
                            dump_off_r <= 1'b1;
                        end else if (len_r != LEN_ZERO) begin
                            len_r <= len_r - LEN_ONE;
                        end
                    end
                end
                DONE: begin
                    if (vs_edge_s) begin
                        frame_cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    dump_en_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.frame_cnt = frame_cnt_r;
    assign bus.frame_stb = frame_stb_r;
    assign bus.dump_en   = dump_en_r;
    assign bus.dump_on   = dump_on_r;
    assign bus.dump_off  = dump_off_r;
    assign bus.state     = state_r;

endmodule

// File: tb/tb_frame_dump_trigger.sv
// Directed bench for frame_dump_trigger: a 32-bit and a 4-bit counter instance share vs/downloading.
module tb_frame_dump_trigger;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    frame_dump_if #(.CW(32), .LW(16)) bus32 ();
    frame_dump_if #(.CW(4),  .LW(16)) bus4 ();

    frame_dump_trigger #(.CW(32), .LW(16), .VS_POL(1'b0)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32)
    );
    frame_dump_trigger #(.CW(4), .LW(16), .VS_POL(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );

    always #5 clk = ~clk;

    assign bus4.vs          = bus32.vs;
    assign bus4.downloading = bus32.downloading;

    // Event monitor sampled on the falling edge
    int          on32_n = 0, off32_n = 0, en32_n = 0, on4_n = 0, off4_n = 0;
    logic [31:0] on32_at = 32'd0, off32_at = 32'd0;
    always @(negedge clk) begin
        if (bus32.dump_on) begin on32_n++; on32_at = bus32.frame_cnt; end
        if (bus32.dump_off) begin off32_n++; off32_at = bus32.frame_cnt; end
        if (bus32.frame_stb && bus32.dump_en) en32_n++;
        if (bus4.dump_on) on4_n++;
        if (bus4.dump_off) off4_n++;
    end

    // Snapshot of both instances at the frame_stb cycle
    logic [31:0] s_cnt;
    logic        s_on, s_off, s_en;
    logic [1:0]  s_st;
    logic [3:0]  s4_cnt;
    logic        s4_on, s4_off;
    logic [1:0]  s4_st;

    int b_on, b_off, b_en, b4_on, b4_off;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic frame();
        bit seen;
        seen = 1'b0;
        @(posedge clk); #2;
        bus32.vs = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus32.frame_stb) begin
                seen   = 1'b1;
                s_cnt  = bus32.frame_cnt;
                s_on   = bus32.dump_on;
                s_off  = bus32.dump_off;
                s_en   = bus32.dump_en;
                s_st   = bus32.state;
                s4_cnt = bus4.frame_cnt;
                s4_on  = bus4.dump_on;
                s4_off = bus4.dump_off;
                s4_st  = bus4.state;
            end
        end
        check_val("stb_seen", 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        bus32.vs = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic do_reset(input logic [31:0] sf, input logic [15:0] dl,
                            input logic [3:0] sf4, input logic [15:0] dl4, input logic dn);
        rst_n             = 1'b0;
        bus32.vs          = 1'b1;
        bus32.downloading = dn;
        bus32.start_frame = sf;
        bus32.dump_len    = dl;
        bus4.start_frame  = sf4;
        bus4.dump_len     = dl4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus32.vs          = 1'b1;
        bus32.downloading = 1'b0;
        bus32.start_frame = 32'd0;
        bus32.dump_len    = 16'd0;
        bus4.start_frame  = 4'd0;
        bus4.dump_len     = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_cnt", bus32.frame_cnt, 32'd0);
        check_val("rst_state", 32'(bus32.state), 32'd0);
        check_val("rst_en", 32'(bus32.dump_en), 32'd0);
        check_val("rst_stb", 32'(bus32.frame_stb), 32'd0);
        check_val("rst_on", 32'(bus32.dump_on), 32'd0);
        check_val("rst_off", 32'(bus32.dump_off), 32'd0);

        // Window at frame 3 for two frames
        do_reset(32'd3, 16'd2, 4'd0, 16'd0, 1'b0);
        check_val("t1_armed", 32'(bus32.state), 32'd1);
        check_val("t1_cnt0", bus32.frame_cnt, 32'd0);
        b_on = on32_n; b_off = off32_n; b_en = en32_n;
        for (int k = 1; k <= 8; k++) begin
            frame();
            check_val($sformatf("t1_cnt_%0d", k), s_cnt, 32'(k));
            check_val($sformatf("t1_on_%0d", k), 32'(s_on), 32'(k == 3));
            check_val($sformatf("t1_off_%0d", k), 32'(s_off), 32'(k == 5));
            check_val($sformatf("t1_en_%0d", k), 32'(s_en), 32'(k == 3 || k == 4));
        end
        check_val("t1_state_end", 32'(bus32.state), 32'd3);
        check_val("t1_cnt_end", bus32.frame_cnt, 32'd8);
        check_val("t1_on_count", 32'(on32_n - b_on), 32'd1);
        check_val("t1_off_count", 32'(off32_n - b_off), 32'd1);
        check_val("t1_en_frames", 32'(en32_n - b_en), 32'd2);
        check_val("t1_on_at", on32_at, 32'd3);
        check_val("t1_off_at", off32_at, 32'd5);

        // start_frame 0 opens on the first frame, length 0 never closes
        do_reset(32'd0, 16'd0, 4'd0, 16'd0, 1'b0);
        b_on = on32_n; b_off = off32_n; b_en = en32_n;
        for (int k = 1; k <= 5; k++) begin
            frame();
            check_val($sformatf("t2_on_%0d", k), 32'(s_on), 32'(k == 1));
            check_val($sformatf("t2_en_%0d", k), 32'(s_en), 32'd1);
        end
        check_val("t2_state", 32'(bus32.state), 32'd2);
        check_val("t2_cnt", bus32.frame_cnt, 32'd5);
        check_val("t2_on_count", 32'(on32_n - b_on), 32'd1);
        check_val("t2_off_count", 32'(off32_n - b_off), 32'd0);
        check_val("t2_en_frames", 32'(en32_n - b_en), 32'd5);

        // Asynchronous reset in the middle of the open window
        b_off = off32_n;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_val("t5_en", 32'(bus32.dump_en), 32'd0);
        check_val("t5_cnt", bus32.frame_cnt, 32'd0);
        check_val("t5_state", 32'(bus32.state), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("t5_no_off", 32'(off32_n - b_off), 32'd0);

`ifdef DUMP_LOADROM_EN
        // Frames during download are not counted; window of one frame after it ends
        do_reset(32'd1, 16'd1, 4'd0, 16'd0, 1'b1);
        check_val("t3_idle", 32'(bus32.state), 32'd0);
        b_en = en32_n;
        for (int k = 1; k <= 4; k++) begin
            frame();
            check_val($sformatf("t3_dl_cnt_%0d", k), s_cnt, 32'd0);
            check_val($sformatf("t3_dl_st_%0d", k), 32'(s_st), 32'd0);
        end
        bus32.downloading = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_val("t3_armed", 32'(bus32.state), 32'd1);
        check_val("t3_cnt0", bus32.frame_cnt, 32'd0);
        frame();
        check_val("t3_on", 32'(s_on), 32'd1);
        check_val("t3_on_cnt", s_cnt, 32'd1);
        frame();
        check_val("t3_off", 32'(s_off), 32'd1);
        check_val("t3_done", 32'(s_st), 32'd3);
        check_val("t3_en_frames", 32'(en32_n - b_en), 32'd1);

        // Download restarting during the window aborts it
        do_reset(32'd1, 16'd0, 4'd0, 16'd0, 1'b0);
        frame();
        check_val("t4_dump", 32'(s_st), 32'd2);
        begin
            bit seen_off;
            seen_off = 1'b0;
            @(posedge clk); #2;
            bus32.downloading = 1'b1;
            for (int i = 0; i < 8 && !seen_off; i++) begin
                @(posedge clk); #1;
                if (bus32.dump_off) begin
                    seen_off = 1'b1;
                    check_val("t4_en", 32'(bus32.dump_en), 32'd0);
                    check_val("t4_state", 32'(bus32.state), 32'd0);
                    check_val("t4_cnt", bus32.frame_cnt, 32'd0);
                end
            end
            check_val("t4_off_seen", 32'(seen_off), 32'd1);
            bus32.downloading = 1'b0;
        end
`endif

        // 4-bit counter wraps; window opens once at 15 and closes after 3 frames
        do_reset(32'd0, 16'd0, 4'd15, 16'd3, 1'b0);
        b4_on = on4_n; b4_off = off4_n;
        for (int k = 1; k <= 20; k++) begin
            frame();
            check_val($sformatf("t6_cnt_%0d", k), 32'(s4_cnt), 32'(k % 16));
            check_val($sformatf("t6_on_%0d", k), 32'(s4_on), 32'(k == 15));
            check_val($sformatf("t6_off_%0d", k), 32'(s4_off), 32'(k == 18));
        end
        check_val("t6_state", 32'(bus4.state), 32'd3);
        check_val("t6_cnt_end", 32'(bus4.frame_cnt), 32'd4);
        check_val("t6_on_count", 32'(on4_n - b4_on), 32'd1);
        check_val("t6_off_count", 32'(off4_n - b4_off), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
